beep_pattern_gen: RTL



---
 rtl/beep_pkg.sv | 26 ++
 rtl/tone_gen.sv | 30 +++
 rtl/beep_pattern_gen.sv | 105 ++++++++++
 3 files changed

// File: rtl/beep_pkg.sv
// Shared types and helpers for the beep cadence generator.
// The state encoding, special rate codes and the rate-to-half-period lookup live here.
package beep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_CONT
  } state_t;

  localparam logic [2:0] RATE_OFF  = 3'd0;
  localparam logic [2:0] RATE_CONT = 3'd5;

  // Cadence codes 1..4 select one of four ON/OFF half-period lengths.
  function automatic int half_of(input logic [2:0] rate,
                                 input int h1, input int h2, input int h3, input int h4);
    case (rate)
      3'd1:    return h1;
      3'd2:    return h2;
      3'd3:    return h3;
      default: return h4;
    endcase
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone source: output toggles every TONE_HALF enabled cycles.
// Output is registered; restart or a low enable clears it to 0 on the next edge.
module tone_gen #(
  parameter int CNT_W     = 27,
  parameter int TONE_HALF = 12_500
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tone
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TONE_HALF - 1);

  logic [CNT_W-1:0] tone_cnt;

  always_ff @(posedge clk) begin
    if (reset || !en || restart) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else if (tone_cnt == TERM) begin
      tone_cnt <= '0;
      tone     <= ~tone;
    end else begin
      tone_cnt <= tone_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/beep_pattern_gen.sv
// Buzzer cadence FSM: gates a tone into ON/OFF beeps or a continuous tone by rate code.
// Outputs are registered and track the state one edge after the request is sampled.
module beep_pattern_gen
  import beep_pkg::*;
#(
  parameter int CNT_W     = 27,
  parameter int HALF_R1   = 12_500_000,
  parameter int HALF_R2   = 8_333_333,
  parameter int HALF_R3   = 6_250_000,
  parameter int HALF_R4   = 2_500_000,
  parameter int TONE_HALF = 12_500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rate_sel,
  input  logic       mute,
  output logic       buzzer_out,
  output logic       beep_active,
  output logic       beep_strobe
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] phase_cnt, phase_nxt;
  logic [2:0]       cur_rate, rate_nxt;
  logic [2:0]       eff;
  logic [CNT_W-1:0] half_term;
  logic             phase_end;
  logic             tone_en, tone_restart;

  assign eff       = (mute || rate_sel > RATE_CONT || rate_sel == RATE_OFF) ? RATE_OFF : rate_sel;
  assign half_term = CNT_W'(half_of(cur_rate, HALF_R1, HALF_R2, HALF_R3, HALF_R4) - 1);
  assign phase_end = (phase_cnt == half_term);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      cur_rate    <= RATE_OFF;
      beep_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase_cnt   <= phase_nxt;
      cur_rate    <= rate_nxt;
      beep_strobe <= (state_nxt == ST_ON) && (state != ST_ON);
    end
  end

  // A silent request wins everywhere; otherwise cadence changes wait for the OFF terminal count.
  always_comb begin
    state_nxt = state;
    phase_nxt = '0;
    rate_nxt  = cur_rate;
    if (eff == RATE_OFF) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_CONT: begin
          if (eff == RATE_CONT) begin
            state_nxt = ST_CONT;
          end else begin
            state_nxt = ST_ON;
            rate_nxt  = eff;
          end
        end
        ST_ON: begin
          if (phase_end) state_nxt = ST_OFF;
          else           phase_nxt = phase_cnt + CNT_W'(1);
        end
        ST_OFF: begin
          if (phase_end) begin
            if (eff == RATE_CONT) begin
              state_nxt = ST_CONT;
            end else begin
              state_nxt = ST_ON;
              rate_nxt  = eff;
            end
          end else begin
            phase_nxt = phase_cnt + CNT_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    beep_active = (state == ST_ON) || (state == ST_CONT);
  end

  assign tone_en      = (state_nxt == ST_ON) || (state_nxt == ST_CONT);
  assign tone_restart = ((state_nxt == ST_ON)   && (state != ST_ON)) ||
                        ((state_nxt == ST_CONT) && (state != ST_CONT));

  tone_gen #(
    .CNT_W    (CNT_W),
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .clk    (clk),
    .reset  (reset),
    .en     (tone_en),
    .restart(tone_restart),
    .tone   (buzzer_out)
  );

endmodule
